// File: rtl/perf_dump.sv
// Atomic snapshot of the performance-counter bank, streamed out one counter per
// valid/ready handshake with index, raw value and delta against the previous dump.
module perf_dump #(
    parameter int NUM_CNT = 7,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = 3,
    parameter int SNAP_W  = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_bus,
    input  logic                     snap_req,
    output logic                     snap_busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_idx,
    output logic [CNT_W-1:0]         out_value,
    output logic [CNT_W-1:0]         out_delta,
    output logic                     out_last,
    output logic [SNAP_W-1:0]        snap_count,
    output logic [7:0]               snap_drop
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] shadow [NUM_CNT];
    logic [CNT_W-1:0] prev   [NUM_CNT];
    logic             at_last;

    assign at_last = (idx == IDX_W'(NUM_CNT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= '0;
            snap_count <= '0;
            snap_drop  <= '0;
            // NOTE: shadow/prev are reset on purpose: an aborted stream must leave
            // prev at zero so the next dump reports deltas equal to raw values.
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow[i] <= '0;
                prev[i]   <= '0;
            end
        end else if (state == IDLE) begin
            if (snap_req) begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    shadow[i] <= cnt_bus[i*CNT_W +: CNT_W];
                end
                idx   <= '0;
                state <= SEND;
            end
        end else begin
            // Requests during a dump are never queued, only counted.
            if (snap_req && snap_drop != 8'hFF) begin
                snap_drop <= snap_drop + 8'd1;
            end
            if (out_ready) begin
                prev[idx] <= shadow[idx];
                if (at_last) begin
                    state      <= IDLE;
                    idx        <= '0;
                    snap_count <= snap_count + SNAP_W'(1);
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    assign snap_busy = (state == SEND);
    assign out_valid = (state == SEND);
    assign out_idx   = idx;
    assign out_value = shadow[idx];
    assign out_delta = shadow[idx] - prev[idx];
    assign out_last  = out_valid && at_last;

endmodule

// File: tb/tb_perf_dump.sv
// Directed bench for perf_dump: inputs change and outputs are checked on the
// falling clock edge, against a small model of the shadow/prev registers.
module tb_perf_dump;

    localparam int NUM_CNT = 7;
    localparam int CNT_W   = 32;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic [NUM_CNT*CNT_W-1:0] cnt_bus;
    logic                     snap_req;
    logic                     snap_busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [2:0]               out_idx;
    logic [31:0]              out_value;
    logic [31:0]              out_delta;
    logic                     out_last;
    logic [15:0]              snap_count;
    logic [7:0]               snap_drop;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_shadow [NUM_CNT];
    logic [31:0] model_prev [NUM_CNT];
    int          exp_count  = 0;

    perf_dump dut (
        .clk        (clk),
        .resetn     (resetn),
        .cnt_bus    (cnt_bus),
        .snap_req   (snap_req),
        .snap_busy  (snap_busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_value  (out_value),
        .out_delta  (out_delta),
        .out_last   (out_last),
        .snap_count (snap_count),
        .snap_drop  (snap_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < NUM_CNT; i++) cnt_bus[i*CNT_W +: CNT_W] = exp_shadow[i];
    endtask

    // Present exp_shadow on the bus and pulse snap_req across one rising edge.
    task automatic start_snap();
        drive_bus();
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    // Walk one dump. stall applies ready pattern 1,0,0,1; drop_mask raises
    // snap_req on the handshake cycle of the flagged words; scramble changes
    // cnt_bus every cycle to prove the capture is atomic.
    task automatic stream_check(input bit stall, input logic [6:0] drop_mask, input bit scramble);
        int k = 0;
        int cyc = 0;
        logic [3:0] pat = 4'b1001;
        logic rdy;
        while (k < NUM_CNT && cyc < 100) begin
            check("valid", 32'(out_valid), 32'd1);
            check("busy", 32'(snap_busy), 32'd1);
            check("idx", 32'(out_idx), 32'(k));
            check("value", out_value, exp_shadow[k]);
            check("delta", out_delta, exp_shadow[k] - model_prev[k]);
            check("last", 32'(out_last), 32'(k == NUM_CNT - 1));
            rdy = stall ? pat[3 - (cyc % 4)] : 1'b1;
            out_ready = rdy;
            snap_req = rdy && drop_mask[k];
            if (scramble) begin
                for (int i = 0; i < NUM_CNT; i++) cnt_bus[i*CNT_W +: CNT_W] = $urandom;
            end
            @(negedge clk);
            snap_req = 1'b0;
            if (rdy) begin
                model_prev[k] = exp_shadow[k];
                k++;
            end
            cyc++;
        end
        check("dump_done_in_budget", 32'(k), 32'(NUM_CNT));
        exp_count++;
        out_ready = 1'b1;
        check("valid_after_dump", 32'(out_valid), 32'd0);
        check("busy_after_dump", 32'(snap_busy), 32'd0);
        check("snap_count", 32'(snap_count), 32'(exp_count));
    endtask

    initial begin
        resetn    = 1'b0;
        cnt_bus   = '0;
        snap_req  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_CNT; i++) model_prev[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(snap_busy), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_count", 32'(snap_count), 32'd0);
        check("rst_drop", 32'(snap_drop), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Basic dump, ready held high: deltas equal values.
        for (int i = 0; i < NUM_CNT; i++) exp_shadow[i] = 32'(100 + i);
        start_snap();
        stream_check(1'b0, 7'b0, 1'b0);

        // Delta wrap-around on counter 2.
        for (int i = 0; i < NUM_CNT; i++) exp_shadow[i] = 32'(200 + 3 * i);
        exp_shadow[2] = 32'hFFFF_FFF0;
        start_snap();
        stream_check(1'b0, 7'b0, 1'b0);
        for (int i = 0; i < NUM_CNT; i++) exp_shadow[i] = 32'(500 + 7 * i);
        exp_shadow[2] = 32'h0000_0010;
        start_snap();
        check("wrap_idx2_prev", model_prev[2], 32'hFFFF_FFF0);
        stream_check(1'b0, 7'b0, 1'b0);

        // Backpressure with a scrambled bus during SEND.
        for (int i = 0; i < NUM_CNT; i++) exp_shadow[i] = 32'h1234_0000 + 32'(i * 17);
        start_snap();
        stream_check(1'b1, 7'b0, 1'b1);

        // Three dropped requests, the last on the final handshake.
        for (int i = 0; i < NUM_CNT; i++) exp_shadow[i] = 32'h00AB_0000 + 32'(i);
        start_snap();
        stream_check(1'b0, 7'b1001010, 1'b0);
        check("drop_count", 32'(snap_drop), 32'd3);
        repeat (3) @(negedge clk);
        check("no_rearm_valid", 32'(out_valid), 32'd0);
        check("no_rearm_count", 32'(snap_count), 32'(exp_count));

        // snap_drop saturation while stalled.
        for (int i = 0; i < NUM_CNT; i++) exp_shadow[i] = 32'(900 + i);
        start_snap();
        out_ready = 1'b0;
        for (int n = 0; n < 300; n++) begin
            snap_req = 1'b1;
            @(negedge clk);
            snap_req = 1'b0;
            @(negedge clk);
        end
        check("drop_saturated", 32'(snap_drop), 32'd255);
        check("stalled_idx", 32'(out_idx), 32'd0);
        stream_check(1'b0, 7'b0, 1'b0);
        check("drop_still_sat", 32'(snap_drop), 32'd255);

        // Asynchronous reset while word 3 is presented.
        for (int i = 0; i < NUM_CNT; i++) exp_shadow[i] = 32'(70 + i);
        start_snap();
        repeat (3) @(negedge clk);
        check("pre_abort_idx", 32'(out_idx), 32'd3);
        out_ready = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("async_valid_drop", 32'(out_valid), 32'd0);
        check("async_busy_drop", 32'(snap_busy), 32'd0);
        check("async_count_clr", 32'(snap_count), 32'd0);
        check("async_drop_clr", 32'(snap_drop), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        out_ready = 1'b1;
        exp_count = 0;
        for (int i = 0; i < NUM_CNT; i++) model_prev[i] = '0;
        @(negedge clk);
        for (int i = 0; i < NUM_CNT; i++) exp_shadow[i] = 32'd5;
        start_snap();
        check("post_reset_delta0", out_delta, 32'd5);
        stream_check(1'b0, 7'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
